// File: rtl/g9_program_loader_if.sv
// Byte-stream ingress and instruction-memory write port of the G9 program loader.
// slave = loader side, master = stream source / memory side.
interface g9_program_loader_if #(
  parameter int size      = 32,
  parameter int AddrWidth = 9
);
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 imem_wea;
  logic [AddrWidth-1:0] imem_addra;
  logic [size-1:0]      imem_dina;

  modport slave  (input  in_data, in_valid,
                  output in_ready, imem_wea, imem_addra, imem_dina);
  modport master (output in_data, in_valid,
                  input  in_ready, imem_wea, imem_addra, imem_dina);
endinterface

// File: rtl/g9_program_loader.sv
// Loads a length-prefixed byte image into imem as big-endian words, one write 1 cycle after each 4th data byte.
// Byte stream is stalled (in_ready=0) in FLUSH/RUN/ERR; optional image checksum via G9_LOADER_CHECKSUM_EN.
module g9_program_loader #(
  parameter int size      = 32,
  parameter int MemSize   = 512,
  parameter int AddrWidth = 9
) (
  input  logic             clk,
  input  logic             reset,
  g9_program_loader_if.slave bus,
  input  logic             reload,
  output logic             cpu_run,
  output logic             busy,
  output logic             error
);

  typedef enum logic [2:0] {
    CNT_HI, CNT_LO, DATA,
`ifdef G9_LOADER_CHECKSUM_EN
    CSUM,
`endif
    FLUSH, RUN, ERR
  } state_t;

`ifdef G9_LOADER_CHECKSUM_EN
  localparam state_t DataDone = CSUM;
`else
  localparam state_t DataDone = FLUSH;
`endif

  state_t               state;
  state_t               state_nxt;
  logic [7:0]           cnt_hi;
  logic [15:0]          n_words;
  logic [15:0]          count_in;
  logic [1:0]           byte_cnt;
  logic [23:0]          asm_q;
  logic [AddrWidth:0]   word_idx;
  logic                 accept;
  logic                 last_word;
  logic                 loading_nxt;
  logic                 busy_nxt;
`ifdef G9_LOADER_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  assign accept   = bus.in_valid && bus.in_ready;
  assign count_in = {cnt_hi, bus.in_data};

  always_comb begin
    state_nxt   = state;
    last_word   = (16'(word_idx) + 16'd1) == n_words;
    case (state)
      CNT_HI: if (accept) state_nxt = CNT_LO;
      CNT_LO: if (accept) begin
        if (count_in > 16'(MemSize))   state_nxt = ERR;
        else if (count_in == 16'd0)    state_nxt = DataDone;
        else                           state_nxt = DATA;
      end
      DATA: if (accept && byte_cnt == 2'd3 && last_word) state_nxt = DataDone;
`ifdef G9_LOADER_CHECKSUM_EN
      CSUM: if (accept) state_nxt = (bus.in_data == csum) ? FLUSH : ERR;
`endif
      FLUSH:    state_nxt = RUN;
      RUN, ERR: if (reload) state_nxt = CNT_HI;
      default:  state_nxt = CNT_HI;
    endcase

    loading_nxt = (state_nxt == CNT_HI) || (state_nxt == CNT_LO) || (state_nxt == DATA);
`ifdef G9_LOADER_CHECKSUM_EN
    loading_nxt = loading_nxt || (state_nxt == CSUM);
`endif
    busy_nxt = loading_nxt || (state_nxt == FLUSH);
  end

  // Outputs are registered from the next-state decode so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= CNT_HI;
      cnt_hi         <= 8'd0;
      n_words        <= 16'd0;
      byte_cnt       <= 2'd0;
      asm_q          <= 24'd0;
      word_idx       <= '0;
      bus.in_ready   <= 1'b1;
      bus.imem_wea   <= 1'b0;
      bus.imem_addra <= '0;
      bus.imem_dina  <= '0;
      cpu_run        <= 1'b0;
      busy           <= 1'b1;
      error          <= 1'b0;
`ifdef G9_LOADER_CHECKSUM_EN
      csum           <= 8'd0;
`endif
    end else begin
      state        <= state_nxt;
      bus.in_ready <= loading_nxt;
      busy         <= busy_nxt;
      cpu_run      <= (state_nxt == RUN);
      error        <= (state_nxt == ERR);
      bus.imem_wea <= 1'b0;

      if (state == CNT_HI && accept) cnt_hi  <= bus.in_data;
      if (state == CNT_LO && accept) n_words <= count_in;

      if (state == DATA && accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_q    <= {asm_q[15:0], bus.in_data};
`ifdef G9_LOADER_CHECKSUM_EN
        csum     <= csum ^ bus.in_data;
`endif
        if (byte_cnt == 2'd3) begin
          bus.imem_wea   <= 1'b1;
          bus.imem_addra <= word_idx[AddrWidth-1:0];
          bus.imem_dina  <= size'({asm_q, bus.in_data});
          word_idx       <= word_idx + 1'b1;
        end
      end

      if ((state == RUN || state == ERR) && reload) begin
        word_idx <= '0;
        byte_cnt <= 2'd0;
`ifdef G9_LOADER_CHECKSUM_EN
        csum     <= 8'd0;
`endif
      end
    end
  end

endmodule
